uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_bit_timer.sv | 33 +++
 rtl/uart_tx.sv | 115 +++++++++++
 tb/tb_uart_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding, framing constants.
// Imported by the transmitter, its bit timer, and the receiver.
package uart_pkg;

  // Default bit period in i_Clock cycles (f_clk / baud).
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // 8N1 framing.
  localparam int START_BITS = 1;
  localparam int DATA_BITS  = 8;

  // 3-bit state encodings, common to both link directions.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and holds there.
// Ports: i_Clock, i_Rst (async, high), i_Clear, o_Tick (at terminal count).
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_Clock,
  input  logic i_Rst,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_Count;

  assign o_Tick = (r_Count == TC);

  // Holds at terminal count until cleared; never wraps.
  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      r_Count <= '0;
    end else if (i_Clear) begin
      r_Count <= '0;
    end else if (!o_Tick) begin
      r_Count <= r_Count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter, configurable stop bits, registered line output.
// Ports: i_Clock, i_Rst (async, high), i_Tx_DV, i_Tx_Byte[7:0],
//        o_Tx_Ready, o_Tx_Active, o_Tx_Serial, o_Tx_Done.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Active,
  output logic       o_Tx_Serial,
  output logic       o_Tx_Done
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t r_State;
  logic [7:0]  r_Tx_Data;
  logic [2:0]  r_Bit;
  logic        w_Tick;
  logic        w_Clear;

  // Timer restarts in idle/cleanup and at every bit boundary.
  assign w_Clear = (r_State == S_IDLE)
                 || (r_State == S_CLEANUP)
                 || w_Tick;

  assign o_Tx_Ready = (r_State == S_IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .i_Clock(i_Clock),
    .i_Rst  (i_Rst),
    .i_Clear(w_Clear),
    .o_Tick (w_Tick)
  );

  // Outputs are registered, so they trail the state by one edge.
  always_ff @(posedge i_Clock or posedge i_Rst) begin
    if (i_Rst) begin
      r_State     <= S_IDLE;
      r_Tx_Data   <= '0;
      r_Bit       <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      case (r_State)
        S_IDLE: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          o_Tx_Done   <= 1'b0;
          r_Bit       <= '0;
          if (i_Tx_DV) begin
            r_Tx_Data <= i_Tx_Byte;
            r_State   <= S_START;
          end
        end
        S_START: begin
          o_Tx_Serial <= 1'b0;
          o_Tx_Active <= 1'b1;
          if (w_Tick) begin
            r_State <= S_DATA;
          end
        end
        S_DATA: begin
          o_Tx_Serial <= r_Tx_Data[r_Bit];
          o_Tx_Active <= 1'b1;
          if (w_Tick) begin
            if (r_Bit == LAST_DATA) begin
              r_Bit   <= '0;
              r_State <= S_STOP;
            end else begin
              r_Bit <= r_Bit + 1'b1;
            end
          end
        end
        S_STOP: begin
          // r_Bit is reused to count stop bits.
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b1;
          if (w_Tick) begin
            if (r_Bit == LAST_STOP) begin
              r_Bit   <= '0;
              r_State <= S_CLEANUP;
            end else begin
              r_Bit <= r_Bit + 1'b1;
            end
          end
        end
        S_CLEANUP: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          o_Tx_Done   <= 1'b1;
          r_State     <= S_IDLE;
        end
        default: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
          o_Tx_Done   <= 1'b0;
          r_Bit       <= '0;
          r_State     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits), table vectors,
// random frames, a behavioural line receiver, back-to-back and reset cases.
module tb_uart_tx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dv  = 2'b00;
  logic [7:0] byte_in [2];
  logic [1:0] rdy, act, ser, done;

  int checks = 0;
  int errors = 0;

  logic [7:0] sentq[$];
  logic [7:0] rxq[$];

  typedef struct {
    int         dut;
    logic [7:0] data;
    logic [9:0] frame;
    bit         mid_dv;
    logic [7:0] junk;
  } vec_t;

  vec_t tbl [7];

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut1 (
    .i_Clock    (clk),
    .i_Rst      (rst),
    .i_Tx_DV    (dv[0]),
    .i_Tx_Byte  (byte_in[0]),
    .o_Tx_Ready (rdy[0]),
    .o_Tx_Active(act[0]),
    .o_Tx_Serial(ser[0]),
    .o_Tx_Done  (done[0])
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
    .i_Clock    (clk),
    .i_Rst      (rst),
    .i_Tx_DV    (dv[1]),
    .i_Tx_Byte  (byte_in[1]),
    .o_Tx_Ready (rdy[1]),
    .o_Tx_Active(act[1]),
    .o_Tx_Serial(ser[1]),
    .o_Tx_Done  (done[1])
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // Receiver model: falling edge, mid-bit sampling, stop must be high.
  initial begin : rx_model
    logic       prev;
    logic [7:0] sh;
    prev = 1'b1;
    sh   = '0;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && ser[0] === 1'b0 && !rst) begin
        repeat (CPB / 2) @(negedge clk);
        if (ser[0] === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            sh[i] = ser[0];
          end
          repeat (CPB) @(negedge clk);
          if (ser[0] === 1'b1) rxq.push_back(sh);
        end
      end
      prev = ser[0];
    end
  end

  task automatic wait_ready(input int d);
    int n;
    n = 0;
    while (rdy[d] !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("ready_before_dv d%0d", d), rdy[d], 1);
  endtask

  // Sends one byte and checks every cycle against the expected frame.
  task automatic send_frame(input int d,
                            input logic [7:0] data,
                            input logic [9:0] fr,
                            input bit mid,
                            input logic [7:0] junk);
    int   len;
    logic eb;
    len = ((d == 0) ? 10 : 11) * CPB;
    wait_ready(d);
    dv[d]      = 1'b1;
    byte_in[d] = data;
    @(negedge clk);
    dv[d]      = 1'b0;
    byte_in[d] = junk;
    chk($sformatf("accept_line_idle d%0d", d), ser[d], 1);
    chk($sformatf("accept_ready_low d%0d", d), rdy[d], 0);
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (mid && k == len / 2) dv[d] = 1'b1;
      if (mid && k == len / 2 + 1) dv[d] = 1'b0;
      eb = (k / CPB < 10) ? fr[k / CPB] : 1'b1;
      chk($sformatf("line d%0d k%0d", d, k), ser[d], eb);
      chk($sformatf("active d%0d k%0d", d, k), act[d], 1);
      chk($sformatf("ready d%0d k%0d", d, k), rdy[d], 0);
      chk($sformatf("done d%0d k%0d", d, k), done[d], 0);
    end
    @(negedge clk);
    chk($sformatf("done_pulse d%0d", d), done[d], 1);
    chk($sformatf("done_active_low d%0d", d), act[d], 0);
    chk($sformatf("done_line_high d%0d", d), ser[d], 1);
    @(negedge clk);
    chk($sformatf("done_cleared d%0d", d), done[d], 0);
    chk($sformatf("ready_after d%0d", d), rdy[d], 1);
    if (mid) begin
      repeat (2 * CPB) @(negedge clk);
      chk($sformatf("dropped_dv_active d%0d", d), act[d], 0);
      chk($sformatf("dropped_dv_line d%0d", d), ser[d], 1);
    end
  endtask

  initial begin
    logic [7:0] data;
    int         d, gap;
    bit         mid;
    logic       expq[$];
    logic [9:0] fa, fb;

    byte_in[0] = '0;
    byte_in[1] = '0;

    tbl[0] = '{0, 8'h55, 10'h2AA, 1'b0, 8'h00};
    tbl[1] = '{0, 8'hA3, 10'h346, 1'b0, 8'h5C};
    tbl[2] = '{0, 8'h00, 10'h200, 1'b0, 8'hFF};
    tbl[3] = '{0, 8'hFF, 10'h3FE, 1'b0, 8'h00};
    tbl[4] = '{0, 8'h12, 10'h224, 1'b1, 8'h34};
    tbl[5] = '{1, 8'h80, 10'h300, 1'b0, 8'h7F};
    tbl[6] = '{1, 8'h3C, 10'h278, 1'b1, 8'hC3};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_line d%0d", i), ser[i], 1);
      chk($sformatf("reset_active d%0d", i), act[i], 0);
      chk($sformatf("reset_done d%0d", i), done[i], 0);
      chk($sformatf("reset_ready d%0d", i), rdy[i], 1);
    end
    rst = 1'b0;
    @(negedge clk);
    rxq.delete();

    for (int i = 0; i < 7; i++) begin
      send_frame(tbl[i].dut, tbl[i].data, tbl[i].frame,
                 tbl[i].mid_dv, tbl[i].junk);
      if (tbl[i].dut == 0) sentq.push_back(tbl[i].data);
    end

    for (int n = 0; n < 24; n++) begin
      d    = int'($urandom_range(0, 1));
      data = 8'($urandom);
      gap  = int'($urandom_range(0, 6));
      mid  = 1'($urandom_range(0, 1));
      repeat (gap) @(negedge clk);
      send_frame(d, data, {1'b1, data, 1'b0}, mid, 8'($urandom));
      if (d == 0) sentq.push_back(data);
    end

    repeat (4) @(negedge clk);
    chk("rx_count", rxq.size(), sentq.size());
    for (int i = 0; i < sentq.size() && i < rxq.size(); i++) begin
      chk($sformatf("rx_byte %0d", i), rxq[i], sentq[i]);
    end

    // DV held high: two frames separated by exactly two idle cycles.
    fa = {1'b1, 8'h01, 1'b0};
    fb = {1'b1, 8'h02, 1'b0};
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < CPB; c++) expq.push_back(fa[b]);
    expq.push_back(1'b1);
    expq.push_back(1'b1);
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < CPB; c++) expq.push_back(fb[b]);
    wait_ready(0);
    dv[0]      = 1'b1;
    byte_in[0] = 8'h01;
    @(negedge clk);
    byte_in[0] = 8'h02;
    chk("b2b_accept_line", ser[0], 1);
    for (int k = 0; k < expq.size(); k++) begin
      @(negedge clk);
      if (k == 100) dv[0] = 1'b0;
      chk($sformatf("b2b_line k%0d", k), ser[0], expq[k]);
      if (k == 80) begin
        chk("b2b_done1", done[0], 1);
        chk("b2b_ready_gap", rdy[0], 1);
      end
      if (k == 81) chk("b2b_ready_restart", rdy[0], 0);
    end
    @(negedge clk);
    chk("b2b_done2", done[0], 1);
    repeat (2 * CPB) @(negedge clk);
    chk("b2b_no_third", act[0], 0);

    // Reset during data bit 3.
    wait_ready(0);
    dv[0]      = 1'b1;
    byte_in[0] = 8'h5A;
    @(negedge clk);
    dv[0] = 1'b0;
    repeat (8 + 3 * 8 + 4) @(negedge clk);
    chk("pre_reset_active", act[0], 1);
    chk("pre_reset_bit3", ser[0], 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_line_async", ser[0], 1);
    chk("rst_active_async", act[0], 0);
    chk("rst_ready_async", rdy[0], 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("rst_no_done %0d", i), done[0], 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_done %0d", i), done[0], 0);
      chk($sformatf("post_rst_active %0d", i), act[0], 0);
    end
    send_frame(0, 8'hC5, {1'b1, 8'hC5, 1'b0}, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
